// File: rtl/aes_inv_key_sched.sv
// Reverse AES key schedule. It loads the last Nk words of an expanded key and
// walks the expansion recurrence backwards one word per cycle. It streams round
// keys Nr..0 over valid/ready, and presents the cipher key on the final beat.
module aes_inv_key_sched #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [32*Nk-1:0] last_key,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [127:0]     rk_data,
    output logic [3:0]       rk_idx,
    output logic             rk_last,
    output logic [32*Nk-1:0] key_out
);
    localparam int         W      = 4 * (Nr + 1);
    localparam logic [5:0] J_LOAD = 6'(W - Nk);
    localparam logic [3:0] R_LOAD = 4'(Nr);
    localparam logic [5:0] NK6    = 6'(Nk);

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

    // Round constant sits in the first (most significant) byte of the word.
    function automatic logic [31:0] rcon(input logic [5:0] k);
        logic [7:0] rc;
        case (k)
            6'd1:    rc = 8'h01;
            6'd2:    rc = 8'h02;
            6'd3:    rc = 8'h04;
            6'd4:    rc = 8'h08;
            6'd5:    rc = 8'h10;
            6'd6:    rc = 8'h20;
            6'd7:    rc = 8'h40;
            6'd8:    rc = 8'h80;
            6'd9:    rc = 8'h1b;
            6'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h0};
    endfunction

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;

    // win[k] holds w[j+k]
    logic [Nk-1:0][31:0] win;
    logic [5:0]          j;
    logic [3:0]          r_out;

    logic       run, xfer, step;
    logic [3:0] r_eff;
    logic [5:0] off, i_idx, i_mod, i_div;
    logic [31:0] g, new_w;

    // Backward recovery: w[i-Nk] = w[i] ^ g_i(w[i-1]) with i the top window word
    always_comb begin
        i_idx = j + 6'(Nk - 1);
        i_mod = i_idx % NK6;
        i_div = i_idx / NK6;
        g     = win[Nk-2];
        if (i_mod == 6'd0)
            g = sub_word(rot_word(win[Nk-2])) ^ rcon(i_div);
        else if (Nk > 6 && i_mod == 6'd4)
            g = sub_word(win[Nk-2]);
        new_w = win[Nk-1] ^ g;
    end

    // Output selection, handshake and step qualification
    always_comb begin
        run      = (state == RUN);
        rk_valid = run && (j <= {r_out, 2'b00});
        off      = {r_out, 2'b00} - j;
        rk_data  = '0;
        if (rk_valid) begin
            for (int o = 0; o <= Nk - 4; o++)
                if (off == 6'(o)) rk_data = win[o +: 4];
        end
        rk_idx  = r_out;
        rk_last = rk_valid && (r_out == 4'd0);
        key_out = (run && j == 6'd0) ? win : '0;
        xfer    = rk_valid && rk_ready;
        r_eff   = xfer ? r_out - 4'd1 : r_out;
        // The top word may be dropped only once no unsent round key needs it
        step    = run && (j != 6'd0) && ({r_eff, 2'b11} <= j + 6'(Nk - 2));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and load handshake
    always_comb begin
        state_nx  = state;
        key_ready = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) state_nx = RUN;
            end
            RUN: if (xfer && r_out == 4'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Window, word pointer and round pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win   <= '0;
            j     <= '0;
            r_out <= '0;
        end else if (state == IDLE) begin
            if (key_valid) begin
                win   <= last_key;
                j     <= J_LOAD;
                r_out <= R_LOAD;
            end
        end else begin
            if (step) begin
                win <= {win[Nk-2:0], new_w};
                j   <= j - 6'd1;
            end
            if (xfer && r_out != 4'd0) r_out <= r_out - 4'd1;
        end
    end
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: forward-expansion model feeds a scoreboard per
// key size; a negedge monitor pops and compares every transferred round key.
module tb_aes_inv_key_sched;
    logic clk = 1'b0, rst_n = 1'b1, rk_ready = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic kv4 = 0, kv6 = 0, kv8 = 0, kr4, kr6, kr8;
    logic [127:0] lk4 = '0, ko4;
    logic [191:0] lk6 = '0, ko6;
    logic [255:0] lk8 = '0, ko8;
    logic rv4, rv6, rv8, rl4, rl6, rl8;
    logic [127:0] rd4, rd6, rd8;
    logic [3:0] ri4, ri6, ri8;

    aes_inv_key_sched #(.Nk(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .key_valid(kv4), .key_ready(kr4),
        .last_key(lk4), .rk_valid(rv4), .rk_ready(rk_ready), .rk_data(rd4), .rk_idx(ri4),
        .rk_last(rl4), .key_out(ko4));
    aes_inv_key_sched #(.Nk(6)) u_dut6 (.clk(clk), .rst_n(rst_n), .key_valid(kv6), .key_ready(kr6),
        .last_key(lk6), .rk_valid(rv6), .rk_ready(rk_ready), .rk_data(rd6), .rk_idx(ri6),
        .rk_last(rl6), .key_out(ko6));
    aes_inv_key_sched #(.Nk(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .key_valid(kv8), .key_ready(kr8),
        .last_key(lk8), .rk_valid(rv8), .rk_ready(rk_ready), .rk_data(rd8), .rk_idx(ri8),
        .rk_last(rl8), .key_out(ko8));

    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // ---- model: forward expansion with an S-box derived from GF(2^8) inverse
    logic [7:0] sbt [256];
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = x;
        for (int k = 0; k < 253; k++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction
    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
    endfunction
    task automatic expand(input int nk, input logic [255:0] key, output logic [31:0] w [60]);
        logic [31:0] t;
        logic [7:0] rc;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int k = 1; k < i / nk; k++) rc = xt(rc);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
    endtask

    // ---- scoreboard
    typedef struct {
        logic [3:0]   idx;
        logic [127:0] data;
        logic         last;
        logic [255:0] key;
    } beat_t;
    beat_t q4[$], q6[$], q8[$];

    function automatic int qsize(input int n);
        case (n)
            4:       return q4.size();
            6:       return q6.size();
            default: return q8.size();
        endcase
    endfunction
    function automatic beat_t qpop(input int n);
        case (n)
            4:       return q4.pop_front();
            6:       return q6.pop_front();
            default: return q8.pop_front();
        endcase
    endfunction
    task automatic qpush(input int n, input beat_t b);
        case (n)
            4:       q4.push_back(b);
            6:       q6.push_back(b);
            default: q8.push_back(b);
        endcase
    endtask

    task automatic prep(input int n, input logic [255:0] key, output logic [255:0] lk);
        logic [31:0] w [60];
        beat_t b;
        int ww = 4 * (n + 7);
        expand(n, key, w);
        for (int r = n + 6; r >= 0; r--) begin
            b.idx  = 4'(r);
            b.data = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
            b.last = (r == 0);
            b.key  = key;
            qpush(n, b);
        end
        lk = '0;
        for (int k = 0; k < n; k++) lk[32*k +: 32] = w[ww-n+k];
    endtask

    // ---- monitor
    logic ps [3];
    logic [127:0] pd [3];
    logic [3:0] pi [3];
    int bcyc [16];
    int load_cyc = 0, last_cyc4 = 0;
    logic [127:0] first4 = '0, lastd4 = '0;
    logic [255:0] lastk4 = '0;

    task automatic mon(input int s, input int n, input logic v, input logic [3:0] idx,
                       input logic [127:0] d, input logic l, input logic [255:0] k);
        beat_t b;
        if (ps[s]) begin
            chk("stall_valid", 256'(v), 256'(1));
            chk("stall_data", 256'(d), 256'(pd[s]));
            chk("stall_idx", 256'(idx), 256'(pi[s]));
        end
        ps[s] = v && !rk_ready;
        pd[s] = d;
        pi[s] = idx;
        if (v && rk_ready) begin
            chk("beat_expected", 256'(qsize(n) != 0), 256'(1));
            if (qsize(n) != 0) begin
                b = qpop(n);
                chk("rk_idx", 256'(idx), 256'(b.idx));
                chk("rk_data", 256'(d), 256'(b.data));
                chk("rk_last", 256'(l), 256'(b.last));
                if (b.last) chk("key_out", k, b.key);
            end
            if (n == 4) begin
                bcyc[idx] = cyc;
                if (idx == 4'd10) first4 = d;
                if (l) begin
                    lastd4 = d;
                    lastk4 = k;
                    last_cyc4 = cyc;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, 4, rv4, ri4, rd4, rl4, 256'(ko4));
            mon(1, 6, rv6, ri6, rd6, rl6, 256'(ko6));
            mon(2, 8, rv8, ri8, rd8, rl8, ko8);
        end else begin
            for (int s = 0; s < 3; s++) ps[s] = 1'b0;
        end
    end

    // ---- drivers
    task automatic drive(input int n, input logic [255:0] lk);
        case (n)
            4:       begin lk4 = lk[127:0]; kv4 = 1'b1; end
            6:       begin lk6 = lk[191:0]; kv6 = 1'b1; end
            default: begin lk8 = lk;        kv8 = 1'b1; end
        endcase
    endtask
    function automatic logic acc(input int n);
        case (n)
            4:       return kv4 && kr4;
            6:       return kv6 && kr6;
            default: return kv8 && kr8;
        endcase
    endfunction
    task automatic wait_acc(input int n);
        int t = 0;
        @(negedge clk);
        while (!acc(n) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("load_accept", 256'(acc(n)), 256'(1));
        load_cyc = cyc;
        @(posedge clk);
        #1;
        kv4 = 1'b0; kv6 = 1'b0; kv8 = 1'b0;
    endtask
    task automatic load(input int n, input logic [255:0] lk);
        drive(n, lk);
        wait_acc(n);
    endtask
    task automatic drain(input int n);
        int t = 0;
        while (qsize(n) != 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", 256'(qsize(n)), 256'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask
    function automatic logic [255:0] rkey(input int n);
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = (i < n) ? 32'($urandom) : 32'h0;
        return k;
    endfunction
    task automatic run(input int n, input logic [255:0] key, input bit rnd);
        logic [255:0] lk;
        int t = 0;
        rk_ready = 1'b1;
        prep(n, key, lk);
        load(n, lk);
        while (qsize(n) != 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
            if (rnd) rk_ready = 1'($urandom_range(0, 1));
        end
        rk_ready = 1'b1;
        drain(n);
    endtask

    localparam logic [255:0] FIPS_KEY  = 256'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [255:0] FIPS_LAST = 256'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;

    initial begin
        logic [255:0] lk;
        int t;
        bit held;
        for (int b = 0; b < 256; b++) sbt[b] = sbox_calc(8'(b));
        for (int s = 0; s < 3; s++) ps[s] = 1'b0;
        #1 rst_n = 1'b0;
        #20;
        chk("rst_key_ready", 256'(kr4), 256'(1));
        chk("rst_rk_valid", 256'(rv4), 256'(0));
        chk("rst_rk_idx", 256'(ri4), 256'(0));
        chk("rst_rk_data", 256'(rd4), 256'(0));
        chk("rst_rk_last", 256'(rl4), 256'(0));
        chk("rst_key_out", 256'(ko4), 256'(0));
        chk("rst_key_ready8", 256'(kr8), 256'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // FIPS-197 A.1 with rk_ready high: values and beat timing
        rk_ready = 1'b1;
        prep(4, FIPS_KEY, lk);
        load(4, FIPS_LAST);
        drain(4);
        chk("fips_first", 256'(first4), FIPS_LAST);
        chk("fips_last", 256'(lastd4), FIPS_KEY);
        chk("fips_key_out", lastk4, FIPS_KEY);
        chk("lat_first", 256'(bcyc[10] - load_cyc), 256'(1));
        for (int r = 9; r >= 0; r--) chk("beat_gap", 256'(bcyc[r] - bcyc[r+1]), 256'(4));
        chk("lat_done", 256'(bcyc[0] - load_cyc), 256'(41));

        // key_valid during RUN ignored; held through final beat, taken in IDLE
        prep(4, rkey(4), lk);
        load(4, lk);
        repeat (3) @(posedge clk);
        #1;
        prep(4, rkey(4), lk);
        drive(4, lk);
        @(negedge clk);
        chk("run_key_ready", 256'(kr4), 256'(0));
        wait_acc(4);
        chk("reload_after_last", 256'(load_cyc - last_cyc4), 256'(1));
        drain(4);

        // Backpressure: random ready with a 20-cycle stall on round 7
        prep(4, rkey(4), lk);
        load(4, lk);
        held = 1'b0;
        t = 0;
        while (q4.size() != 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
            if (!held && rv4 && ri4 == 4'd7) begin
                rk_ready = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                held = 1'b1;
            end
            rk_ready = ($urandom_range(0, 9) < 3);
        end
        chk("bp_stall_seen", 256'(held), 256'(1));
        rk_ready = 1'b1;
        drain(4);

        // Asynchronous reset mid-run, then a fresh full sequence
        prep(4, rkey(4), lk);
        load(4, lk);
        t = 0;
        while (!(rv4 && ri4 == 4'd5) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("reach_r5", 256'(ri4), 256'(5));
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_rk_valid", 256'(rv4), 256'(0));
        chk("mrst_key_ready", 256'(kr4), 256'(1));
        q4.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(4, rkey(4), 1'b0);

        // Larger keys against the forward model
        for (int rep = 0; rep < 2; rep++) begin
            run(6, rkey(6), rep[0]);
            run(8, rkey(8), rep[0]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end
endmodule
